multicycle_cpu: RTL and testbench

//   Parametrised multi-cycle MIPS-subset core; successor to the single-cycle top. One FSM sequences a

---
 rtl/multicycle_cpu_if.sv | 31 +++
 rtl/multicycle_cpu.sv | 253 +++++++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cpu_if.sv
// multicycle_cpu_if
//   Unified instruction/data memory bus with a req/ready handshake.
//   An access completes in any cycle where mem_req & mem_ready are both high;
//   the master holds mem_addr/mem_we/mem_wdata stable until then.
//   Signals:
//     mem_req   master->slave  access request
//     mem_we    master->slave  1 = store, 0 = load/fetch
//     mem_addr  master->slave  byte address (word aligned), ADDR_W bits
//     mem_wdata master->slave  store data
//     mem_rdata slave->master  read data, valid while mem_ready is high
//     mem_ready slave->master  access completes this cycle
interface multicycle_cpu_if #(
  parameter int ADDR_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_cpu.sv
// multicycle_cpu
//   Multi-cycle MIPS-subset core (add/sub/and/or/slt, lw, sw, beq, bne, addi, j).
//   A single FSM sequences one shared ALU and one unified memory port, so
//   memories with any number of wait states can be attached.
//   Ports:
//     clk     clock, all state updates on the rising edge
//     reset   synchronous, active-high
//     mem     memory bus (master side of multicycle_cpu_if)
//     retire  one-cycle pulse per completed instruction
//     pc_dbg  address of the instruction held in IR
//     trap    sticky: illegal opcode/funct or misaligned lw/sw; cleared only by reset
module multicycle_cpu #(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          REGS_CLR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_cpu_if.master mem,
  output logic             retire,
  output logic [31:0]      pc_dbg,
  output logic             trap
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB_R, WB_I, WB_L, TRAP} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t      state, stateNext;
  logic [31:0] pcReg, pcDbgReg, irReg, aReg, bReg, aluOutReg, mdrReg;
  logic [31:0] regFile [32];

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] immExt;
  assign opcode = irReg[31:26];
  assign rs     = irReg[25:21];
  assign rt     = irReg[20:16];
  assign rd     = irReg[15:11];
  assign funct  = irReg[5:0];
  assign immExt = {{16{irReg[15]}}, irReg[15:0]};

  logic isRType, isJump, isBranch, isAddi, isLw, isSw, isLegal, misaligned;
  assign isRType    = (opcode == OP_RTYPE);
  assign isJump     = (opcode == OP_J);
  assign isBranch   = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign isAddi     = (opcode == OP_ADDI);
  assign isLw       = (opcode == OP_LW);
  assign isSw       = (opcode == OP_SW);
  assign isLegal    = (isRType && (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}))
                   || isJump || isBranch || isAddi || isLw || isSw;
  assign misaligned = |aluOutReg[1:0];

  // Register file reads; R0 is forced to zero so it needs no reset
  logic [31:0] rsVal, rtVal;
  assign rsVal = (rs == 5'd0) ? 32'd0 : regFile[rs];
  assign rtVal = (rt == 5'd0) ? 32'd0 : regFile[rt];

  // Shared ALU: pc+4 in FETCH, branch target in DECODE, execute op in EXEC
  logic [31:0] aluA, aluB, aluY;
  alu_op_t     aluOp;
  logic        aluZero;

  always_comb begin
    aluA  = pcReg;
    aluB  = 32'd4;
    aluOp = ALU_ADD;
    case (state)
      DECODE: aluB = {immExt[29:0], 2'b00};
      EXEC: begin
        aluA = aReg;
        if (isRType) begin
          aluB = bReg;
          case (funct)
            FN_SUB:  aluOp = ALU_SUB;
            FN_AND:  aluOp = ALU_AND;
            FN_OR:   aluOp = ALU_OR;
            FN_SLT:  aluOp = ALU_SLT;
            default: aluOp = ALU_ADD;
          endcase
        end else if (isBranch) begin
          // equality is taken from the zero flag of A-B
          aluB  = bReg;
          aluOp = ALU_SUB;
        end else begin
          aluB = immExt;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (aluOp)
      ALU_SUB: aluY = aluA - aluB;
      ALU_AND: aluY = aluA & aluB;
      ALU_OR:  aluY = aluA | aluB;
      ALU_SLT: aluY = {31'd0, $signed(aluA) < $signed(aluB)};
      default: aluY = aluA + aluB;
    endcase
  end
  assign aluZero = (aluY == 32'd0);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= stateNext;
  end

  // FSM: next state
  always_comb begin
    stateNext = state;
    case (state)
      FETCH:  if (mem.mem_ready) stateNext = DECODE;
      DECODE: begin
        if (!isLegal)    stateNext = TRAP;
        else if (isJump) stateNext = FETCH;
        else             stateNext = EXEC;
      end
      EXEC: begin
        if (isRType)      stateNext = WB_R;
        else if (isAddi)  stateNext = WB_I;
        else if (isBranch) stateNext = FETCH;
        else              stateNext = MEM;
      end
      MEM: begin
        if (misaligned)          stateNext = TRAP;
        else if (mem.mem_ready)  stateNext = isSw ? FETCH : WB_L;
      end
      WB_R, WB_I, WB_L: stateNext = FETCH;
      TRAP:   stateNext = TRAP;
      default: stateNext = FETCH;
    endcase
  end

  // FSM: outputs
  logic              memReq, memWe, retireInt, regWrite;
  logic [ADDR_W-1:0] memAddr;
  logic [4:0]        regDest;
  logic [31:0]       regData;

  always_comb begin
    memReq    = 1'b0;
    memWe     = 1'b0;
    memAddr   = pcReg[ADDR_W-1:0];
    retireInt = 1'b0;
    regWrite  = 1'b0;
    regDest   = rt;
    regData   = aluOutReg;
    case (state)
      FETCH:  memReq = 1'b1;
      DECODE: retireInt = isJump;
      EXEC:   retireInt = isBranch;
      MEM: begin
        // a misaligned address never reaches the bus
        memAddr   = aluOutReg[ADDR_W-1:0];
        memReq    = !misaligned;
        memWe     = isSw && !misaligned;
        retireInt = isSw && !misaligned && mem.mem_ready;
      end
      WB_R: begin
        regWrite  = 1'b1;
        regDest   = rd;
        retireInt = 1'b1;
      end
      WB_I: begin
        regWrite  = 1'b1;
        retireInt = 1'b1;
      end
      WB_L: begin
        regWrite  = 1'b1;
        regData   = mdrReg;
        retireInt = 1'b1;
      end
      default: ;
    endcase
    // reset kills any in-flight access in the very cycle it is sampled
    if (reset) begin
      memReq    = 1'b0;
      memWe     = 1'b0;
      retireInt = 1'b0;
      regWrite  = 1'b0;
    end
  end

  assign mem.mem_req   = memReq;
  assign mem.mem_we    = memWe;
  assign mem.mem_addr  = memAddr;
  assign mem.mem_wdata = bReg;
  assign retire        = retireInt;
  assign pc_dbg        = pcDbgReg;
  assign trap          = (state == TRAP) && !reset;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg     <= RESET_PC;
      pcDbgReg  <= RESET_PC;
      irReg     <= 32'd0;
      aReg      <= 32'd0;
      bReg      <= 32'd0;
      aluOutReg <= 32'd0;
      mdrReg    <= 32'd0;
    end else begin
      case (state)
        FETCH: if (mem.mem_ready) begin
          irReg    <= mem.mem_rdata;
          pcDbgReg <= pcReg;
          pcReg    <= aluY;
        end
        DECODE: begin
          aReg      <= rsVal;
          bReg      <= rtVal;
          aluOutReg <= aluY;
          if (isJump) pcReg <= {pcReg[31:28], irReg[25:0], 2'b00};
        end
        EXEC: begin
          if (isBranch) begin
            // ALUOut holds the target computed in DECODE
            if (aluZero ^ (opcode == OP_BNE)) pcReg <= aluOutReg;
          end else begin
            aluOutReg <= aluY;
          end
        end
        MEM: if (mem.mem_ready && isLw && !misaligned) mdrReg <= mem.mem_rdata;
        default: ;
      endcase
    end
  end

  // Register file: writes to R0 are dropped
  always_ff @(posedge clk) begin
    if (reset && REGS_CLR) begin
      for (int i = 0; i < 32; i++) regFile[i] <= 32'd0;
    end else if (regWrite && (regDest != 5'd0)) begin
      regFile[regDest] <= regData;
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        retire;
  logic [31:0] pc_dbg;
  logic        trap;

  multicycle_cpu_if #(.ADDR_W(16)) memBus ();

  multicycle_cpu #(.ADDR_W(16), .RESET_PC(32'h0000_0000), .REGS_CLR(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem    (memBus),
    .retire (retire),
    .pc_dbg (pc_dbg),
    .trap   (trap)
  );

  always #5 clk = ~clk;

  // ---------------- memory model with programmable wait states ----------------
  logic [31:0] memArr [1024];
  int          waitStates = 0;
  bit          stall = 1'b0;
  int          waitCtr = 0;

  assign memBus.mem_ready = memBus.mem_req && !stall && (waitCtr >= waitStates);
  assign memBus.mem_rdata = memArr[memBus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (reset || !memBus.mem_req) begin
      waitCtr <= 0;
    end else if (memBus.mem_ready) begin
      waitCtr <= 0;
      if (memBus.mem_we) memArr[memBus.mem_addr[11:2]] = memBus.mem_wdata;
    end else begin
      waitCtr <= waitCtr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { int cyc; logic [31:0] pc; } ret_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  ret_t expRet[$];
  st_t  expSt[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int retireCnt = 0;
  int txCnt = 0;
  bit running = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops expectations when the DUT retires or stores
  ret_t        r;
  st_t         s;
  bit          prevWait = 1'b0;
  logic [15:0] prevAddr;
  logic        prevWe;
  logic [31:0] prevWdata;

  always @(negedge clk) begin
    if (running) begin
      cyc++;
      if (retire) begin
        retireCnt++;
        if (expRet.size() > 0) begin
          r = expRet.pop_front();
          if (r.cyc >= 0) check("retire_cycle", 32'(cyc), 32'(r.cyc));
          check("retire_pc", pc_dbg, r.pc);
          $display("retire  cyc=%0d pc=%h", cyc, pc_dbg);
        end
      end
      if (prevWait) begin
        check("hs_req_held", 32'(memBus.mem_req), 32'd1);
        check("hs_addr_stable", 32'(memBus.mem_addr), 32'(prevAddr));
        check("hs_we_stable", 32'(memBus.mem_we), 32'(prevWe));
        if (prevWe) check("hs_wdata_stable", memBus.mem_wdata, prevWdata);
      end
      if (memBus.mem_req && memBus.mem_ready) begin
        txCnt++;
        if (memBus.mem_we) begin
          check("store_expected", 32'(expSt.size() != 0), 32'd1);
          if (expSt.size() > 0) begin
            s = expSt.pop_front();
            check("store_addr", 32'(memBus.mem_addr), s.addr);
            check("store_data", memBus.mem_wdata, s.data);
            $display("store   cyc=%0d addr=%h data=%h", cyc, memBus.mem_addr, memBus.mem_wdata);
          end
        end
      end
      prevWait  = memBus.mem_req && !memBus.mem_ready;
      prevAddr  = memBus.mem_addr;
      prevWe    = memBus.mem_we;
      prevWdata = memBus.mem_wdata;
    end else begin
      prevWait = 1'b0;
    end
  end

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rsF,
                                        input logic [4:0] rtF, input logic [15:0] imm);
    return {op, rsF, rtF, imm};
  endfunction

  function automatic logic [31:0] rType(input logic [4:0] rsF, input logic [4:0] rtF,
                                        input logic [4:0] rdF, input logic [5:0] fn);
    return {6'h00, rsF, rtF, rdF, 5'd0, fn};
  endfunction

  function automatic logic [31:0] jType(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic startReset();
    @(negedge clk);
    reset   = 1'b1;
    running = 1'b0;
    stall   = 1'b0;
    for (int i = 0; i < 1024; i++) memArr[i] = 32'd0;
    expRet.delete();
    expSt.delete();
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(memBus.mem_req), 32'd0);
    check("rst_mem_we", 32'(memBus.mem_we), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_pc_dbg", pc_dbg, 32'h0000_0000);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cyc       = 0;
    retireCnt = 0;
    txCnt     = 0;
    running   = 1'b1;
  endtask

  task automatic expectRet(input int c, input logic [31:0] pc);
    ret_t e;
    e.cyc = c;
    e.pc  = pc;
    expRet.push_back(e);
  endtask

  task automatic expectSt(input logic [31:0] a, input logic [31:0] d);
    st_t e;
    e.addr = a;
    e.data = d;
    expSt.push_back(e);
  endtask

  task automatic drained(input string tag);
    check({tag, "_retires_left"}, 32'(expRet.size()), 32'd0);
    check({tag, "_stores_left"}, 32'(expSt.size()), 32'd0);
    expRet.delete();
    expSt.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Test 1: ALU ops, zero-wait memory, 4-cycle cadence
    waitStates = 0;
    startReset();
    memArr[0]  = iType(6'h08, 5'd0, 5'd1, 16'd5);
    memArr[1]  = iType(6'h08, 5'd0, 5'd2, 16'd7);
    memArr[2]  = rType(5'd1, 5'd2, 5'd3, 6'h20);
    memArr[3]  = iType(6'h2B, 5'd0, 5'd3, 16'h0040);
    memArr[4]  = rType(5'd1, 5'd2, 5'd5, 6'h22);
    memArr[5]  = rType(5'd5, 5'd1, 5'd6, 6'h2A);
    memArr[6]  = rType(5'd1, 5'd2, 5'd7, 6'h24);
    memArr[7]  = rType(5'd5, 5'd2, 5'd8, 6'h25);
    memArr[8]  = iType(6'h2B, 5'd0, 5'd5, 16'h0044);
    memArr[9]  = iType(6'h2B, 5'd0, 5'd6, 16'h0048);
    memArr[10] = iType(6'h2B, 5'd0, 5'd7, 16'h004C);
    memArr[11] = iType(6'h2B, 5'd0, 5'd8, 16'h0050);
    memArr[12] = jType(26'd12);
    for (int i = 0; i < 12; i++) expectRet(4 * (i + 1), 32'(4 * i));
    expectSt(32'h40, 32'd12);
    expectSt(32'h44, 32'hFFFF_FFFE);
    expectSt(32'h48, 32'd1);
    expectSt(32'h4C, 32'd5);
    expectSt(32'h50, 32'hFFFF_FFFF);
    releaseReset();
    @(negedge clk);
    check("t1_first_fetch_addr", 32'(memBus.mem_addr), 32'h0);
    repeat (55) @(negedge clk);
    drained("t1");

    // Test 2: sw then lw with 3 wait states per access
    waitStates = 3;
    startReset();
    memArr[0] = iType(6'h08, 5'd0, 5'd3, 16'd12);
    memArr[1] = iType(6'h2B, 5'd0, 5'd3, 16'h0040);
    memArr[2] = iType(6'h23, 5'd0, 5'd4, 16'h0040);
    memArr[3] = iType(6'h2B, 5'd0, 5'd4, 16'h0044);
    memArr[4] = jType(26'd4);
    expectRet(7, 32'h0);
    expectRet(17, 32'h4);
    expectRet(28, 32'h8);
    expectRet(38, 32'hC);
    expectSt(32'h40, 32'd12);
    expectSt(32'h44, 32'd12);
    releaseReset();
    repeat (60) @(negedge clk);
    drained("t2");
    waitStates = 0;

    // Test 3: bne falls through, beq -1 loops every 3 cycles
    startReset();
    memArr[0] = iType(6'h08, 5'd0, 5'd1, 16'd1);
    memArr[1] = iType(6'h05, 5'd1, 5'd1, 16'd4);
    memArr[2] = iType(6'h08, 5'd0, 5'd2, 16'd3);
    memArr[3] = iType(6'h2B, 5'd0, 5'd2, 16'h0040);
    memArr[4] = iType(6'h04, 5'd1, 5'd1, 16'hFFFF);
    expectRet(4, 32'h0);
    expectRet(7, 32'h4);
    expectRet(11, 32'h8);
    expectRet(15, 32'hC);
    for (int i = 0; i < 4; i++) expectRet(18 + 3 * i, 32'h10);
    expectSt(32'h40, 32'd3);
    releaseReset();
    repeat (30) @(negedge clk);
    drained("t3");

    // Test 4: jump to 0x400, write to r0 discarded
    startReset();
    memArr[0]     = iType(6'h08, 5'd0, 5'd1, 16'd1);
    memArr[1]     = iType(6'h08, 5'd0, 5'd0, 16'd9);
    memArr[2]     = jType(26'h100);
    memArr[16]    = 32'hDEAD_BEEF;
    memArr[256]   = iType(6'h2B, 5'd0, 5'd0, 16'h0040);
    memArr[257]   = jType(26'h101);
    expectRet(4, 32'h0);
    expectRet(8, 32'h4);
    expectRet(-1, 32'h8);
    expectRet(-1, 32'h400);
    expectSt(32'h40, 32'd0);
    releaseReset();
    repeat (30) @(negedge clk);
    drained("t4");

    // Test 5a: illegal opcode traps, bus goes quiet
    startReset();
    memArr[0] = iType(6'h08, 5'd0, 5'd1, 16'd1);
    memArr[1] = 32'hFC00_0000;
    releaseReset();
    repeat (10) @(negedge clk);
    check("t5a_trap", 32'(trap), 32'd1);
    check("t5a_retires", 32'(retireCnt), 32'd1);
    check("t5a_tx", 32'(txCnt), 32'd2);
    repeat (20) @(negedge clk);
    check("t5a_trap_sticky", 32'(trap), 32'd1);
    check("t5a_req_low", 32'(memBus.mem_req), 32'd0);
    check("t5a_retires_after", 32'(retireCnt), 32'd1);
    check("t5a_tx_after", 32'(txCnt), 32'd2);

    // Test 5b: misaligned lw traps without touching memory
    startReset();
    memArr[0] = iType(6'h23, 5'd0, 5'd4, 16'h0042);
    releaseReset();
    repeat (10) @(negedge clk);
    check("t5b_trap", 32'(trap), 32'd1);
    check("t5b_retires", 32'(retireCnt), 32'd0);
    check("t5b_tx", 32'(txCnt), 32'd1);
    check("t5b_req_low", 32'(memBus.mem_req), 32'd0);
    startReset();
    memArr[0] = iType(6'h08, 5'd0, 5'd1, 16'd1);
    releaseReset();
    @(negedge clk);
    check("t5b_restart_req", 32'(memBus.mem_req), 32'd1);
    check("t5b_restart_addr", 32'(memBus.mem_addr), 32'h0);
    check("t5b_restart_trap", 32'(trap), 32'd0);

    // Test 6: reset while FETCH waits on mem_ready
    startReset();
    memArr[0] = iType(6'h08, 5'd0, 5'd1, 16'd5);
    memArr[1] = iType(6'h2B, 5'd0, 5'd1, 16'h0040);
    memArr[2] = jType(26'd2);
    releaseReset();
    repeat (4) @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_stalled_req", 32'(memBus.mem_req), 32'd1);
    check("t6_stalled_addr", 32'(memBus.mem_addr), 32'h4);
    check("t6_stalled_pc_dbg", pc_dbg, 32'h0);
    reset   = 1'b1;
    running = 1'b0;
    #1;
    check("t6_req_drop", 32'(memBus.mem_req), 32'd0);
    @(posedge clk);
    #1;
    check("t6_pc_reset_addr", 32'(memBus.mem_addr), 32'h0);
    check("t6_req_in_reset", 32'(memBus.mem_req), 32'd0);
    stall = 1'b0;
    expectRet(4, 32'h0);
    expectRet(8, 32'h4);
    expectSt(32'h40, 32'd5);
    releaseReset();
    repeat (20) @(negedge clk);
    drained("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
